// File: rtl/mpc_types.sv
// Shared types for the memory pipeline: the number of crossbar channels and the issue FSM state encoding.
package mpc_types;

   localparam int MPC_CH_NUM  = 3;
   localparam int STALL_CNT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } isu_iss_state_e;

endpackage

// File: rtl/isu_oldest_pick.sv
// Picks the oldest requesting LSQ slot, where age runs upward from base_i and wraps at N-1 -> 0.
// The picker is purely combinational and applies no backpressure.
module isu_oldest_pick #(
   parameter int N     = 16,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] base_i,
   output logic             found_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [IDX_W-1:0] slot;

   // Scan from youngest to oldest so the last hit (smallest offset from base) wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      slot    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         slot = base_i + IDX_W'(i);
         if (req_i[slot]) begin
            found_o = 1'b1;
            idx_o   = slot;
         end
      end
   end

endmodule

// File: rtl/isu_issue_scheduler.sv
// Issues the oldest credited LSQ entry on each of three xbar channels, with a 1-cycle latency from credit to valid.
// Each request holds stable while iss_ready is low, and a per-channel counter flags a stall that lasts too long.
module isu_issue_scheduler
   import mpc_types::*;
#(
   parameter int LSQ_SIZE  = 16,
   parameter int IDX_W     = $clog2(LSQ_SIZE),
   parameter int STALL_MAX = 255
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  flush,
   input  logic [LSQ_SIZE-1:0]                   lsq_entry_vld,
   input  logic [LSQ_SIZE-1:0]                   entry_can_execute,
   input  logic [LSQ_SIZE-1:0][1:0]              lsq_entry_channel_id,
   input  logic [IDX_W-1:0]                      lsq_btm_ptr,
   output logic [MPC_CH_NUM-1:0]                 iss_valid,
   output logic [MPC_CH_NUM-1:0][IDX_W-1:0]      iss_lsq_idx,
   input  logic [MPC_CH_NUM-1:0]                 iss_ready,
   output logic [LSQ_SIZE-1:0]                   entry_issued,
   output logic [MPC_CH_NUM-1:0]                 stall_err
);

   localparam logic [STALL_CNT_W-1:0] STALL_LIMIT = STALL_CNT_W'(STALL_MAX);

   isu_iss_state_e                          state_q [MPC_CH_NUM];
   isu_iss_state_e                          state_d [MPC_CH_NUM];
   logic [MPC_CH_NUM-1:0][IDX_W-1:0]        idx_q, idx_d;
   logic [MPC_CH_NUM-1:0][STALL_CNT_W-1:0]  cnt_q, cnt_d;
   logic [MPC_CH_NUM-1:0]                   err_q, err_d;
   logic [LSQ_SIZE-1:0]                     issued_q, issued_d;

   logic [MPC_CH_NUM-1:0][LSQ_SIZE-1:0]     pick_req;
   logic [MPC_CH_NUM-1:0]                   pick_found;
   logic [MPC_CH_NUM-1:0][IDX_W-1:0]        pick_idx;

   // While a channel is in REQ its own entry is masked out, so the pick is the back-to-back successor.
   always_comb begin
      pick_req = '0;
      for (int c = 0; c < MPC_CH_NUM; c++) begin
         for (int e = 0; e < LSQ_SIZE; e++) begin
            pick_req[c][e] = lsq_entry_vld[e] & entry_can_execute[e] & ~issued_q[e] &
                             (lsq_entry_channel_id[e] == 2'(c));
         end
         if (state_q[c] == REQ) begin
            pick_req[c][idx_q[c]] = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < MPC_CH_NUM; g++) begin : g_pick
      isu_oldest_pick #(
         .N     (LSQ_SIZE),
         .IDX_W (IDX_W)
      ) u_pick (
         .req_i   (pick_req[g]),
         .base_i  (lsq_btm_ptr),
         .found_o (pick_found[g]),
         .idx_o   (pick_idx[g])
      );
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      issued_d = issued_q & lsq_entry_vld;
      for (int c = 0; c < MPC_CH_NUM; c++) begin
         case (state_q[c])
            IDLE: begin
               cnt_d[c] = '0;
               if (pick_found[c]) begin
                  state_d[c] = REQ;
                  idx_d[c]   = pick_idx[c];
               end
            end
            REQ: begin
               if (iss_ready[c]) begin
                  issued_d[idx_q[c]] = 1'b1;
                  cnt_d[c]           = '0;
                  if (pick_found[c]) begin
                     idx_d[c] = pick_idx[c];
                  end else begin
                     state_d[c] = IDLE;
                  end
               end else begin
                  if (cnt_q[c] != '1) begin
                     cnt_d[c] = cnt_q[c] + 1'b1;
                  end
                  if (cnt_d[c] == STALL_LIMIT) begin
                     err_d[c] = 1'b1;
                  end
               end
            end
            default: state_d[c] = IDLE;
         endcase
      end
      if (flush) begin
         state_d  = '{default: IDLE};
         cnt_d    = '0;
         issued_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= '{default: IDLE};
         idx_q    <= '0;
         cnt_q    <= '0;
         err_q    <= '0;
         issued_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         issued_q <= issued_d;
      end
   end

   always_comb begin
      for (int c = 0; c < MPC_CH_NUM; c++) begin
         iss_valid[c] = (state_q[c] == REQ);
      end
   end

   assign iss_lsq_idx  = idx_q;
   assign entry_issued = issued_q;
   assign stall_err    = err_q;

endmodule

// File: tb/tb_isu_issue_scheduler.sv
// Bench for isu_issue_scheduler. It runs a table of picker vectors, then hand-written multi-cycle sequences.
// A scoreboard queue holds the expected handshakes, and a monitor checks each one as it occurs.
module tb_isu_issue_scheduler;
   import mpc_types::*;

   localparam int N  = 16;
   localparam int IW = 4;

   logic                 clk = 1'b0;
   logic                 rst, flush;
   logic [N-1:0]         vld, can;
   logic [N-1:0][1:0]    chan;
   logic [IW-1:0]        btm;
   logic [2:0]           iss_valid, iss_ready;
   logic [2:0][IW-1:0]   iss_idx;
   logic [N-1:0]         issued;
   logic [2:0]           stall_err;

   int n_cmp = 0;
   int n_mis = 0;
   int sb_q[$];
   int exp_hs;

   typedef struct {
      logic [15:0] m0, m1, m2, m3, cn;
      logic [3:0]  b;
      logic [2:0]  ev;
      logic [3:0]  e0, e1, e2;
   } vec_t;
   vec_t vt[10];

   always #5 clk = ~clk;

   isu_issue_scheduler #(.LSQ_SIZE(N), .IDX_W(IW), .STALL_MAX(255)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .flush                (flush),
      .lsq_entry_vld        (vld),
      .entry_can_execute    (can),
      .lsq_entry_channel_id (chan),
      .lsq_btm_ptr          (btm),
      .iss_valid            (iss_valid),
      .iss_lsq_idx          (iss_idx),
      .iss_ready            (iss_ready),
      .entry_issued         (issued),
      .stall_err            (stall_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [N-1:0][1:0] mk_chan(input logic [15:0] m0, m1, m2);
      logic [N-1:0][1:0] r;
      for (int e = 0; e < N; e++) begin
         r[e] = m0[e] ? 2'd0 : m1[e] ? 2'd1 : m2[e] ? 2'd2 : 2'd3;
      end
      return r;
   endfunction

   task automatic apply(input logic [15:0] m0, m1, m2, m3, cn, input logic [3:0] b);
      vld  = m0 | m1 | m2 | m3;
      can  = cn;
      chan = mk_chan(m0, m1, m2);
      btm  = b;
   endtask

   // Check handshakes in the middle of the cycle. The LSQ must keep an entry allocated while a channel requests it.
   always @(negedge clk) begin
      if (!rst && !flush) begin
         for (int c = 0; c < 3; c++) begin
            if (iss_valid[c] && iss_ready[c]) begin
               n_cmp++;
               if (sb_q.size() == 0) begin
                  n_mis++;
                  $display("FAIL hs_unexpected: ch%0d idx %0d, expected no handshake", c, iss_idx[c]);
               end else begin
                  exp_hs = sb_q.pop_front();
                  if (exp_hs != c * 16 + int'(iss_idx[c])) begin
                     n_mis++;
                     $display("FAIL hs_order: got ch%0d idx %0d, expected ch%0d idx %0d",
                              c, iss_idx[c], exp_hs / 16, exp_hs % 16);
                  end
               end
            end
            if (iss_valid[c]) begin
               assert (vld[iss_idx[c]]) else begin
                  n_mis++;
                  $display("FAIL dealloc_in_req: ch%0d idx %0d vld 0, expected 1", c, iss_idx[c]);
               end
            end
         end
      end
   end

   initial begin
      vt[0] = '{16'h0208, 16'h0, 16'h0, 16'h0, 16'hFFFF, 4'd0,  3'b001, 4'd3, 4'd0, 4'd0};
      vt[1] = '{16'h0208, 16'h0, 16'h0, 16'h0, 16'hFFFF, 4'd5,  3'b001, 4'd9, 4'd0, 4'd0};
      vt[2] = '{16'h0208, 16'h0, 16'h0, 16'h0, 16'hFFFF, 4'd10, 3'b001, 4'd3, 4'd0, 4'd0};
      vt[3] = '{16'h0, 16'h0, 16'h8001, 16'h0, 16'hFFFF, 4'd15, 3'b100, 4'd0, 4'd0, 4'd15};
      vt[4] = '{16'h0, 16'h0, 16'h8001, 16'h0, 16'hFFFF, 4'd1,  3'b100, 4'd0, 4'd0, 4'd15};
      vt[5] = '{16'h0, 16'h0, 16'h0, 16'h00F0, 16'hFFFF, 4'd0,  3'b000, 4'd0, 4'd0, 4'd0};
      vt[6] = '{16'h0100, 16'h0, 16'h0, 16'h0, 16'hFEFF, 4'd0,  3'b000, 4'd0, 4'd0, 4'd0};
      vt[7] = '{16'h0010, 16'h0044, 16'h0100, 16'h0, 16'hFFFF, 4'd3, 3'b111, 4'd4, 4'd6, 4'd8};
      vt[8] = '{16'h0, 16'h0044, 16'h0, 16'h0, 16'hFFBF, 4'd3,  3'b010, 4'd0, 4'd2, 4'd0};
      vt[9] = '{16'h0100, 16'h0, 16'h0, 16'h0, 16'hFFFF, 4'd8,  3'b001, 4'd8, 4'd0, 4'd0};

      rst = 1'b1; flush = 1'b0; iss_ready = '0;
      apply(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'd0);
      repeat (3) step();
      chk("rst_valid", iss_valid, 0);
      chk("rst_idx", iss_idx, 0);
      chk("rst_issued", issued, 0);
      chk("rst_err", stall_err, 0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         flush = 1'b1; iss_ready = '0;
         apply(vt[i].m0, vt[i].m1, vt[i].m2, vt[i].m3, vt[i].cn, vt[i].b);
         step();
         flush = 1'b0;
         step();
         chk($sformatf("vec%0d_valid", i), iss_valid, vt[i].ev);
         if (vt[i].ev[0]) chk($sformatf("vec%0d_idx0", i), iss_idx[0], vt[i].e0);
         if (vt[i].ev[1]) chk($sformatf("vec%0d_idx1", i), iss_idx[1], vt[i].e1);
         if (vt[i].ev[2]) chk($sformatf("vec%0d_idx2", i), iss_idx[2], vt[i].e2);
      end

      // Oldest-first from btm=14 across the wrap, then back-to-back, then idle.
      flush = 1'b1; iss_ready = '0;
      apply(16'h0, 16'h8004, 16'h0, 16'h0, 16'hFFFF, 4'd14);
      step();
      flush = 1'b0;
      sb_q.push_back(16 + 15);
      sb_q.push_back(16 + 2);
      step();
      chk("wrap_valid", iss_valid, 3'b010);
      chk("wrap_first", iss_idx[1], 15);
      step();
      chk("wrap_hold", {iss_valid, iss_idx[1]}, {3'b010, 4'd15});
      iss_ready = 3'b010;
      step();
      chk("b2b_valid", iss_valid, 3'b010);
      chk("b2b_idx", iss_idx[1], 2);
      chk("b2b_issued15", issued, 16'h8000);
      step();
      chk("b2b_idle", iss_valid, 0);
      chk("b2b_issued", issued, 16'h8004);

      // Two channels hand off in the same cycle.
      flush = 1'b1; iss_ready = 3'b101;
      apply(16'h0008, 16'h0, 16'h0020, 16'h0, 16'hFFFF, 4'd0);
      step();
      flush = 1'b0;
      sb_q.push_back(3);
      sb_q.push_back(32 + 5);
      step();
      chk("dual_valid", iss_valid, 3'b101);
      chk("dual_idx", {iss_idx[2], iss_idx[0]}, {4'd5, 4'd3});
      step();
      chk("dual_issued", issued, 16'h0028);
      chk("dual_idle", iss_valid, 0);

      // A flush during a handshake discards it.
      flush = 1'b1; iss_ready = '0;
      apply(16'h0, 16'h0040, 16'h0, 16'h0, 16'hFFFF, 4'd0);
      step();
      flush = 1'b0;
      step();
      chk("flush_pre", iss_valid, 3'b010);
      iss_ready = 3'b010; flush = 1'b1;
      step();
      chk("flush_valid", iss_valid[1], 0);
      chk("flush_issued", issued, 0);
      flush = 1'b0; iss_ready = '0;
      step();
      chk("flush_retry", iss_valid, 3'b010);

      // Stall on ch0: the request stays stable and the error is sticky once set at 255.
      flush = 1'b1; iss_ready = '0;
      apply(16'h0010, 16'h0, 16'h0, 16'h0, 16'hFFFF, 4'd0);
      step();
      flush = 1'b0;
      step();
      chk("stall_start", {iss_valid, iss_idx[0]}, {3'b001, 4'd4});
      for (int k = 1; k <= 254; k++) begin
         step();
         chk("stall_hold", {iss_valid[0], iss_idx[0]}, {1'b1, 4'd4});
      end
      chk("stall_err_254", stall_err, 0);
      step();
      chk("stall_err_255", stall_err, 3'b001);
      iss_ready = 3'b001;
      sb_q.push_back(4);
      step();
      chk("stall_done", iss_valid, 0);
      chk("stall_err_kept", stall_err, 3'b001);
      chk("stall_issued", issued, 16'h0010);

      // Entry 7 is issued, deallocated, reallocated and then reissued.
      flush = 1'b1; iss_ready = 3'b100;
      apply(16'h0, 16'h0, 16'h0080, 16'h0, 16'hFFFF, 4'd0);
      step();
      flush = 1'b0;
      chk("flush_keeps_err", stall_err, 3'b001);
      sb_q.push_back(32 + 7);
      step();
      chk("realloc_req", {iss_valid, iss_idx[2]}, {3'b100, 4'd7});
      step();
      chk("realloc_issued", issued, 16'h0080);
      vld[7] = 1'b0;
      step();
      chk("realloc_clear", issued, 0);
      vld[7] = 1'b1;
      sb_q.push_back(32 + 7);
      step();
      chk("realloc_reissue", {iss_valid, iss_idx[2]}, {3'b100, 4'd7});
      step();
      chk("realloc_issued2", issued, 16'h0080);

      // A reset during a handshake drops the request without recording it.
      flush = 1'b1; iss_ready = 3'b010;
      apply(16'h0, 16'h0200, 16'h0, 16'h0, 16'hFFFF, 4'd0);
      step();
      flush = 1'b0;
      step();
      chk("rst_hs_pre", iss_valid, 3'b010);
      rst = 1'b1;
      step();
      chk("rst_hs_valid", iss_valid, 0);
      chk("rst_hs_idx", iss_idx, 0);
      chk("rst_hs_issued", issued, 0);
      chk("rst_hs_err", stall_err, 0);
      rst = 1'b0; iss_ready = '0;
      step();

      chk("sb_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/isu_issue_scheduler.md
ISU_ISSUE_SCHEDULER -- requirements
Module: isu_issue_scheduler

Interface
REQ-001 SHALL have parameter LSQ_SIZE, default 16, LSQ entry count (power of 2, >=4).
REQ-002 SHALL have parameter IDX_W, default $clog2(LSQ_SIZE), LSQ index width.
REQ-003 SHALL have parameter STALL_MAX, default 255, ready-low cycles tolerated before stall error (8-bit counter).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  abort all pending issues.
REQ-007 SHALL have port lsq_entry_vld  input  LSQ_SIZE  entry allocated.
REQ-008 SHALL have port entry_can_execute  input  LSQ_SIZE  credit granted to entry.
REQ-009 SHALL have port lsq_entry_channel_id  input  LSQ_SIZE x 2  per-entry xbar channel (0..2; 3 = none).
REQ-010 SHALL have port lsq_btm_ptr  input  IDX_W  oldest LSQ entry.
REQ-011 SHALL have port iss_valid  output  3  per-channel issue request to xbar.
REQ-012 SHALL have port iss_lsq_idx  output  3 x IDX_W  per-channel issued entry index.
REQ-013 SHALL have port iss_ready  input  3  per-channel xbar accept.
REQ-014 SHALL have port entry_issued  output  LSQ_SIZE  entry accepted by xbar.
REQ-015 SHALL have port stall_err  output  3  sticky per-channel stall flag.

Function
REQ-016 Candidate(e,c) SHALL = lsq_entry_vld[e] & entry_can_execute[e] & ~entry_issued[e] & channel_id[e]==c; channel id 3 never a candidate.
REQ-017 Per channel, SHALL select oldest candidate: priority rotated so lsq_btm_ptr highest, wrapping LSQ_SIZE-1 -> 0.
REQ-018 Per-channel FSM states IDLE, REQ; iss_valid[c]=1 iff REQ; iss_lsq_idx[c] registered.
REQ-019 IDLE: candidate exists -> load oldest index, REQ next cycle (1-cycle latency credit->valid); else stay IDLE.
REQ-020 REQ & ~iss_ready: hold iss_valid and iss_lsq_idx stable.
REQ-021 REQ & iss_ready: set entry_issued[idx] next cycle; oldest candidate excluding idx -> load it, stay REQ (back-to-back); else IDLE.
REQ-022 Channels independent; up to 3 handshakes same cycle, all recorded.
REQ-023 entry_issued[e] SHALL clear the cycle after lsq_entry_vld[e]=0; dealloc and reallocation same index in one cycle not supported (LSQ guarantees >=1 invalid cycle).
REQ-024 LSQ SHALL NOT dealloc an entry held in REQ; bench asserts this.
REQ-025 Per channel stall counter: increments in REQ & ~iss_ready, saturates at 255, clears on handshake or IDLE; reaching STALL_MAX sets stall_err[c], cleared only by rst.
REQ-026 flush: all FSMs IDLE, iss_valid=0, entry_issued=0, stall counters=0 next cycle; handshake in flush cycle discarded; stall_err kept; flush wins over all events.

Reset
REQ-027 rst SHALL force IDLE, iss_valid=0, iss_lsq_idx=0, entry_issued=0, stall counters=0, stall_err=0 next edge; mid-handshake reset drops request without recording.

Structure
REQ-028 isu_iss_state_e (IDLE, REQ) and MPC_CH_NUM=3 SHALL live in mpc_types.
REQ-029 Oldest-first rotating picker SHALL be sub-module isu_oldest_pick (inputs req mask, base ptr; outputs found, idx), instantiated 3 times.

Verification
REQ-030 btm=14, ch1 candidates 15,2 -> iss_lsq_idx[1]=15 cycle+1; ready -> then 2 back-to-back, then IDLE.
REQ-031 Candidates ch0 idx 3, ch2 idx 5, both ready high -> both valid same cycle, entry_issued bits 3,5 set next cycle.
REQ-032 ch0 ready low 255 cycles -> iss_valid/idx stable, stall_err[0]=1 at 255, persists after handshake.
REQ-033 flush while ch1 REQ with ready=1 -> entry_issued unchanged-zero, iss_valid[1]=0 next cycle.
REQ-034 Issued entry 7 deallocated then reallocated with credit -> entry_issued[7] clears, 7 reissued.
